// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: shares one UART TX core among N byte requesters using round-robin grants.
// Optional watchdog that aborts a frame the core never acknowledges: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 2**20,
  localparam int IW         = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    rq_valid,
  input  logic [N*8-1:0]  rq_data,
  output logic [N-1:0]    rq_ready,
  output logic [N-1:0]    rq_done,
  input  logic [1:0]      cfg_stop,
  input  logic            cfg_parity_en,
  input  logic [15:0]     cfg_baudrate,
  output logic [7:0]      tx_data,
  output logic [1:0]      stop,
  output logic            parity_en,
  output logic [15:0]     baudrate,
  output logic            req,
  input  logic            req_ack,
  output logic            busy,
  output logic [IW-1:0]   owner,
  output logic            err_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [IW:0] N_W = (IW+1)'(N);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   win;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      stop_q, stop_d;
  logic            parity_en_q, parity_en_d;
  logic [15:0]     baudrate_q, baudrate_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    rq_ready_q, rq_ready_d;
  logic [N-1:0]    rq_done_q, rq_done_d;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYC+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC-1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_W) sum = sum - N_W;
    return sum[IW-1:0];
  endfunction

  // Rotate so bit 0 is the pointer position; the lowest set bit is the winner's offset.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [2*N-1:0] rot;
    logic [N-1:0]   lo;
    logic [IW-1:0]  off;
    rot = {v, v} >> p;
    lo  = rot[N-1:0];
    off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (lo[k[IW-1:0]]) off = k[IW-1:0];
    end
    return wrap_add(p, off);
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    tx_data_d   = tx_data_q;
    stop_d      = stop_q;
    parity_en_d = parity_en_q;
    baudrate_d  = baudrate_q;
    req_d       = req_q;
    busy_d      = busy_q;
    rq_ready_d  = '0;
    rq_done_d   = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    win         = rr_pick(rq_valid, ptr_q);
    case (state_q)
      IDLE, GAP: begin
        if (|rq_valid) begin
          rq_ready_d[win] = 1'b1;
          tx_data_d       = rq_data[8*win +: 8];
          stop_d          = cfg_stop;
          parity_en_d     = cfg_parity_en;
          baudrate_d      = cfg_baudrate;
          owner_d         = win;
          req_d           = 1'b1;
          busy_d          = 1'b1;
          state_d         = BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end else if (state_q == GAP) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (req_ack) begin
          req_d              = 1'b0;
          busy_d             = 1'b0;
          rq_done_d[owner_q] = 1'b1;
          ptr_d              = wrap_add(owner_q, IW'(1));
          state_d            = GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          ptr_d   = wrap_add(owner_q, IW'(1));
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      tx_data_q   <= '0;
      stop_q      <= '0;
      parity_en_q <= 1'b0;
      baudrate_q  <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      rq_ready_q  <= '0;
      rq_done_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      tx_data_q   <= tx_data_d;
      stop_q      <= stop_d;
      parity_en_q <= parity_en_d;
      baudrate_q  <= baudrate_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      rq_ready_q  <= rq_ready_d;
      rq_done_q   <= rq_done_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign rq_ready  = rq_ready_q;
  assign rq_done   = rq_done_q;
  assign tx_data   = tx_data_q;
  assign stop      = stop_q;
  assign parity_en = parity_en_q;
  assign baudrate  = baudrate_q;
  assign req       = req_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants, completions and
// line snapshots into queues; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   rq_valid;
  logic [31:0]  rq_data;
  logic [3:0]   rq_ready;
  logic [3:0]   rq_done;
  logic [1:0]   cfg_stop;
  logic         cfg_parity_en;
  logic [15:0]  cfg_baudrate;
  logic [7:0]   tx_data;
  logic [1:0]   stop;
  logic         parity_en;
  logic [15:0]  baudrate;
  logic         req;
  logic         req_ack;
  logic         busy;
  logic [1:0]   owner;
  logic         err_timeout;

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .resetn(resetn), .rq_valid(rq_valid), .rq_data(rq_data),
    .rq_ready(rq_ready), .rq_done(rq_done), .cfg_stop(cfg_stop),
    .cfg_parity_en(cfg_parity_en), .cfg_baudrate(cfg_baudrate), .tx_data(tx_data),
    .stop(stop), .parity_en(parity_en), .baudrate(baudrate), .req(req),
    .req_ack(req_ack), .busy(busy), .owner(owner), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ready;
    logic [7:0]  data;
    logic [1:0]  st;
    logic        par;
    logic [15:0] bd;
    logic [1:0]  own;
  } grant_t;

  typedef struct {
    logic        r;
    logic        b;
    logic [1:0]  own;
    logic [7:0]  data;
    logic [15:0] bd;
    logic [1:0]  st;
    logic        par;
    logic        err;
  } probe_t;

  grant_t     gq[$];
  probe_t     pq[$];
  logic [3:0] dq[$];
  grant_t     gv;
  probe_t     pv;
  logic [3:0] dv;
  int         n_vec = 0;
  int         n_err = 0;
  logic       drain = 1'b0;
  logic       drained = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every negedge compare whatever the DUT presents against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (pq.size() > 0) begin
        pv = pq.pop_front();
        chk("probe_req",       32'(req),         32'(pv.r));
        chk("probe_busy",      32'(busy),        32'(pv.b));
        chk("probe_owner",     32'(owner),       32'(pv.own));
        chk("probe_tx_data",   32'(tx_data),     32'(pv.data));
        chk("probe_baudrate",  32'(baudrate),    32'(pv.bd));
        chk("probe_stop",      32'(stop),        32'(pv.st));
        chk("probe_parity_en", 32'(parity_en),   32'(pv.par));
        chk("probe_err",       32'(err_timeout), 32'(pv.err));
      end
      if (rq_ready !== 4'b0000) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(rq_ready), 32'(0));
        end else begin
          gv = gq.pop_front();
          chk("grant_ready",     32'(rq_ready),  32'(gv.ready));
          chk("grant_tx_data",   32'(tx_data),   32'(gv.data));
          chk("grant_stop",      32'(stop),      32'(gv.st));
          chk("grant_parity_en", 32'(parity_en), 32'(gv.par));
          chk("grant_baudrate",  32'(baudrate),  32'(gv.bd));
          chk("grant_owner",     32'(owner),     32'(gv.own));
          chk("grant_req",       32'(req),       32'(1));
        end
      end
      if (rq_done !== 4'b0000) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(rq_done), 32'(0));
        end else begin
          dv = dq.pop_front();
          chk("done_mask", 32'(rq_done), 32'(dv));
        end
      end
      if (drain && !drained) begin
        chk("grants_left", 32'(gq.size()), 32'(0));
        chk("dones_left",  32'(dq.size()), 32'(0));
        chk("probes_left", 32'(pq.size()), 32'(0));
        drained = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int own, input logic [7:0] d, input logic [1:0] st,
                              input logic par, input logic [15:0] bd);
    grant_t g;
    g.ready = 4'(1 << own);
    g.data  = d;
    g.st    = st;
    g.par   = par;
    g.bd    = bd;
    g.own   = 2'(own);
    gq.push_back(g);
  endtask

  task automatic probe(input logic r, input logic b, input int own, input logic [7:0] d,
                       input logic [15:0] bd, input logic [1:0] st, input logic par,
                       input logic e);
    probe_t p;
    p.r    = r;
    p.b    = b;
    p.own  = 2'(own);
    p.data = d;
    p.bd   = bd;
    p.st   = st;
    p.par  = par;
    p.err  = e;
    pq.push_back(p);
  endtask

  // One complete frame: grant edge, one BUSY cycle, ack edge; ends in GAP.
  task automatic frame(input int own, input logic [7:0] d, input logic [1:0] st,
                       input logic par, input logic [15:0] bd, input logic last);
    expect_grant(own, d, st, par, bd);
    step();
    probe(1'b1, 1'b1, own, d, bd, st, par, 1'b0);
    step();
    req_ack = 1'b1;
    dq.push_back(4'(1 << own));
    step();
    req_ack = 1'b0;
    probe(1'b0, 1'b0, own, d, bd, st, par, 1'b0);
    if (last) rq_valid = 4'b0000;
  endtask

  initial begin
    resetn = 1'b0; rq_valid = '0; rq_data = '0; req_ack = 1'b0;
    cfg_stop = '0; cfg_parity_en = 1'b0; cfg_baudrate = '0;
    step();
    probe(1'b0, 1'b0, 0, 8'h00, 16'd0, 2'b00, 1'b0, 1'b0);
    step();
    resetn = 1'b1;
    step();

    // First grant with latched line config
    rq_data[7:0] = 8'hA5; cfg_stop = 2'b01; cfg_parity_en = 1'b1; cfg_baudrate = 16'd434;
    rq_valid = 4'b0001;
    expect_grant(0, 8'hA5, 2'b01, 1'b1, 16'd434);
    step();
    rq_valid = 4'b0000; cfg_baudrate = 16'd100; rq_data[7:0] = 8'h5A;
    probe(1'b1, 1'b1, 0, 8'hA5, 16'd434, 2'b01, 1'b1, 1'b0);
    step();
    probe(1'b1, 1'b1, 0, 8'hA5, 16'd434, 2'b01, 1'b1, 1'b0);
    req_ack = 1'b1;
    dq.push_back(4'b0001);
    step();
    req_ack = 1'b0;
    probe(1'b0, 1'b0, 0, 8'hA5, 16'd434, 2'b01, 1'b1, 1'b0);
    rq_valid = 4'b0001;
    expect_grant(0, 8'h5A, 2'b01, 1'b1, 16'd100);
    step();
    rq_valid = 4'b0000;
    probe(1'b1, 1'b1, 0, 8'h5A, 16'd100, 2'b01, 1'b1, 1'b0);
    req_ack = 1'b1;
    dq.push_back(4'b0001);
    step();
    req_ack = 1'b0;
    step();
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    probe(1'b0, 1'b0, 0, 8'h5A, 16'd100, 2'b01, 1'b1, 1'b0);

    // Reset in the middle of a frame (ptr=1 so requester 2 wins)
    rq_data[23:16] = 8'hC3; cfg_stop = 2'b10; cfg_parity_en = 1'b0; cfg_baudrate = 16'd7;
    rq_valid = 4'b0100;
    expect_grant(2, 8'hC3, 2'b10, 1'b0, 16'd7);
    step();
    rq_valid = 4'b0000;
    probe(1'b1, 1'b1, 2, 8'hC3, 16'd7, 2'b10, 1'b0, 1'b0);
    step();
    resetn = 1'b0;
    probe(1'b0, 1'b0, 0, 8'h00, 16'd0, 2'b00, 1'b0, 1'b0);
    step();
    resetn = 1'b1;
    step();

    // All four requesting: 0,1,2,3,0
    rq_data = 32'h44332211; cfg_stop = 2'b11; cfg_parity_en = 1'b0; cfg_baudrate = 16'h1234;
    rq_valid = 4'b1111;
    frame(0, 8'h11, 2'b11, 1'b0, 16'h1234, 1'b0);
    frame(1, 8'h22, 2'b11, 1'b0, 16'h1234, 1'b0);
    frame(2, 8'h33, 2'b11, 1'b0, 16'h1234, 1'b0);
    frame(3, 8'h44, 2'b11, 1'b0, 16'h1234, 1'b0);
    frame(0, 8'h11, 2'b11, 1'b0, 16'h1234, 1'b1);

    // Move ptr to 2, then 0011 wraps to 0 then 1
    rq_valid = 4'b0010;
    frame(1, 8'h22, 2'b11, 1'b0, 16'h1234, 1'b1);
    rq_valid = 4'b0011;
    frame(0, 8'h11, 2'b11, 1'b0, 16'h1234, 1'b0);
    frame(1, 8'h22, 2'b11, 1'b0, 16'h1234, 1'b1);
    step();

`ifdef UART_ARB_TIMEOUT_EN
    rq_valid = 4'b0001;
    expect_grant(0, 8'h11, 2'b11, 1'b0, 16'h1234);
    step();
    rq_valid = 4'b0000;
    repeat (15) step();
    probe(1'b1, 1'b1, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b0);
    step();
    probe(1'b0, 1'b0, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b1);
    step();
    probe(1'b0, 1'b0, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b0);
    step();
    rq_valid = 4'b0001;
    expect_grant(0, 8'h11, 2'b11, 1'b0, 16'h1234);
    step();
    rq_valid = 4'b0000;
    repeat (15) step();
    req_ack = 1'b1;
    dq.push_back(4'b0001);
    step();
    req_ack = 1'b0;
    probe(1'b0, 1'b0, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b0);
`else
    rq_valid = 4'b0001;
    expect_grant(0, 8'h11, 2'b11, 1'b0, 16'h1234);
    step();
    rq_valid = 4'b0000;
    repeat (30) step();
    probe(1'b1, 1'b1, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b0);
    req_ack = 1'b1;
    dq.push_back(4'b0001);
    step();
    req_ack = 1'b0;
    probe(1'b0, 1'b0, 0, 8'h11, 16'h1234, 2'b11, 1'b0, 1'b0);
`endif
    repeat (3) step();
    drain = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
